// File: rtl/gray_code_counter.sv
// gray_code_counter: binary counter with Gray-coded output, IDLE/RUN/DONE control and valid/ready stepping.
// Optional down-counting (port dn) is enabled by defining GRAY_CNT_DOWN_EN.
module gray_code_counter #(
    parameter int WIDTH = 8,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_gray,
`ifdef GRAY_CNT_DOWN_EN
    input  logic             dn,
`endif
    input  logic             ready,
    output logic [WIDTH-1:0] gray_out,
    output logic             valid,
    output logic             tc,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] ld_bin;
    logic             down;
    logic             at_term;
`ifdef GRAY_CNT_DOWN_EN
    assign down = dn;
`else
    assign down = 1'b0;
`endif
    always_comb begin
        ld_bin = ld_gray;
        for (int i = WIDTH - 2; i >= 0; i--) ld_bin[i] = ld_gray[i] ^ ld_bin[i+1];
    end
    assign at_term  = bin_q == (down ? {WIDTH{1'b0}} : {WIDTH{1'b1}});
    assign gray_out = bin_q ^ (bin_q >> 1);
    assign valid    = state_q == RUN;
    assign busy     = state_q != IDLE;
    assign tc       = busy && at_term;
    // A load always wins over a step; only a DONE-state load alters the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
        end else begin
            if (ld) bin_q <= ld_bin;
            case (state_q)
                IDLE: if (start && !stop) state_q <= RUN;
                RUN: begin
                    if (stop) state_q <= IDLE;
                    else if (!ld && ready) begin
                        if (at_term && !WRAP) state_q <= DONE;
                        else bin_q <= down ? bin_q - WIDTH'(1) : bin_q + WIDTH'(1);
                    end
                end
                DONE: begin
                    if (ld || stop) state_q <= IDLE;
                    else if (start) begin
                        state_q <= RUN;
                        bin_q   <= down ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gray_code_counter.sv
// tb_gray_code_counter: directed test of gray_code_counter, one WRAP=1 and one WRAP=0 instance on shared stimulus.
module tb_gray_code_counter;
    logic       clk = 1'b0;
    logic       rst, start, stop, ld, ready;
    logic [7:0] ld_gray;
`ifdef GRAY_CNT_DOWN_EN
    logic       dn;
`endif
    logic [7:0] g1, g0;
    logic       v1, t1, b1, v0, t0, b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(8), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .ld(ld), .ld_gray(ld_gray),
`ifdef GRAY_CNT_DOWN_EN
        .dn(dn),
`endif
        .ready(ready), .gray_out(g1), .valid(v1), .tc(t1), .busy(b1)
    );

    gray_code_counter #(.WIDTH(8), .WRAP(1'b0)) u_stop (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .ld(ld), .ld_gray(ld_gray),
`ifdef GRAY_CNT_DOWN_EN
        .dn(dn),
`endif
        .ready(ready), .gray_out(g0), .valid(v0), .tc(t0), .busy(b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; ld = 1'b0; ready = 1'b0; ld_gray = 8'h00;
`ifdef GRAY_CNT_DOWN_EN
        dn = 1'b0;
`endif
        #3;
        check("rst_gray", g1, 8'h00);
        check("rst_valid", v1, 1'b0);
        check("rst_tc", t1, 1'b0);
        check("rst_busy", b1, 1'b0);
        rst = 1'b0;
        // free count from zero
        start = 1'b1; ready = 1'b1;
        tick;
        start = 1'b0;
        check("run_g0", g1, 8'h00);
        check("run_valid", v1, 1'b1);
        check("run_busy", b1, 1'b1);
        tick; check("run_g1", g1, 8'h01);
        tick; check("run_g2", g1, 8'h03);
        tick; check("run_g3", g1, 8'h02);
        tick; check("run_g4", g1, 8'h06);
        check("run_valid4", v1, 1'b1);
        // asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        check("arst_gray", g1, 8'h00);
        check("arst_valid", v1, 1'b0);
        check("arst_busy", b1, 1'b0);
        #1 rst = 1'b0;
        tick;
        check("arst_idle_valid", v1, 1'b0);
        check("arst_idle_gray", g1, 8'h00);
        // start and stop together stay in IDLE
        start = 1'b1; stop = 1'b1;
        tick; check("ss_busy", b1, 1'b0);
        stop = 1'b0; ready = 1'b0;
        tick; check("start_busy", b1, 1'b1);
        start = 1'b0;
        tick; check("hold_gray", g1, 8'h00);
        ready = 1'b1;
        tick; check("step_gray", g1, 8'h01);
        stop = 1'b1;
        tick;
        check("stop_valid", v1, 1'b0);
        check("stop_gray", g1, 8'h01);
        stop = 1'b0;
        // load in IDLE, then one step
        ld = 1'b1; ld_gray = 8'hE6;
        tick;
        check("ld_gray", g1, 8'hE6);
        check("ld_idle_busy", b1, 1'b0);
        ld = 1'b0; start = 1'b1;
        tick; check("ld_run_gray", g1, 8'hE6);
        start = 1'b0;
        tick; check("ld_step_gray", g1, 8'hE2);
        // load all-ones with ready high: load beats step
        ld = 1'b1; ld_gray = 8'h80;
        tick;
        check("term_gray", g1, 8'h80);
        check("term_tc1", t1, 1'b1);
        check("term_tc0", t0, 1'b1);
        ld = 1'b0;
        tick;
        check("wrap_gray", g1, 8'h00);
        check("wrap_tc", t1, 1'b0);
        check("wrap_valid", v1, 1'b1);
        check("done_valid", v0, 1'b0);
        check("done_tc", t0, 1'b1);
        check("done_busy", b0, 1'b1);
        check("done_gray", g0, 8'h80);
        ready = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        check("restart_gray", g0, 8'h00);
        check("restart_valid", v0, 1'b1);
        // load in DONE returns to IDLE
        ld = 1'b1; ld_gray = 8'h80;
        tick;
        ld = 1'b0; ready = 1'b1;
        tick;
        check("done2_valid", v0, 1'b0);
        ready = 1'b0; ld = 1'b1; ld_gray = 8'h01;
        tick;
        ld = 1'b0;
        check("ld_done_busy", b0, 1'b0);
        check("ld_done_gray", g0, 8'h01);
        check("ld_run_busy", b1, 1'b1);
`ifdef GRAY_CNT_DOWN_EN
        rst = 1'b1;
        #1 rst = 1'b0;
        dn = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        check("dn_start_gray", g1, 8'h00);
        check("dn_start_tc", t1, 1'b1);
        ready = 1'b1;
        tick; check("dn_wrap_gray", g1, 8'h80);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick; check("dn_hold_gray", g1, 8'h80);
        end
        dn = 1'b0;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gray_code_counter.md
GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter and code width in bits; legal range 2..16.
REQ-002 Parameter WRAP, default 1: 1 = free-running wrap at terminal count; 0 = stop in DONE at terminal count.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request entry to RUN.
REQ-006 stop  in  1  request return to IDLE.
REQ-007 ld  in  1  load strobe for ld_gray.
REQ-008 ld_gray  in  WIDTH  Gray-coded load value.
REQ-009 dn  in  1  count direction, 1 = down; present only when GRAY_CNT_DOWN_EN is defined.
REQ-010 ready  in  1  downstream (Gray-to-binary stage) accepts gray_out.
REQ-011 gray_out  out  WIDTH  current count in reflected-binary Gray code.
REQ-012 valid  out  1  gray_out is offered downstream.
REQ-013 tc  out  1  current count is terminal for the current direction.
REQ-014 busy  out  1  FSM is not in IDLE.

Function
REQ-015 Internal state is a WIDTH-bit binary count B; gray_out SHALL equal B XOR (B >> 1) at all times.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE -> RUN on start=1 and stop=0; start and stop both high in IDLE SHALL leave the FSM in IDLE.
REQ-018 RUN -> IDLE on stop=1; stop SHALL take priority over any step in the same cycle, and B SHALL hold.
REQ-019 valid SHALL be 1 only in RUN; busy SHALL be 1 in RUN and in DONE.
REQ-020 Step condition is valid=1 and ready=1; B SHALL change on the next edge (one-cycle latency), +1 up or -1 down.
REQ-021 While valid=1 and ready=0, gray_out SHALL remain stable.
REQ-022 Terminal count is all-ones when counting up and zero when counting down; tc SHALL be 1 when B equals the terminal count in RUN or DONE, else 0.
REQ-023 With WRAP=1, a step at terminal SHALL wrap B (all-ones to 0 up; 0 to all-ones down), and the FSM SHALL stay in RUN.
REQ-024 With WRAP=0, a step at terminal SHALL move the FSM to DONE with B unchanged.
REQ-025 DONE -> RUN on start=1: B SHALL be reset to 0 (up) or all-ones (down); stop in DONE SHALL move the FSM to IDLE with B held.
REQ-026 ld=1 SHALL set B to the binary equivalent of ld_gray (MSB copied, each lower bit = ld_gray bit XOR next-higher result bit) in any state.
REQ-027 ld SHALL take priority over a step in the same cycle and SHALL NOT change the FSM state, except that ld in DONE SHALL move the FSM to IDLE.
REQ-028 A change of dn SHALL take effect on the next step; the current B is not altered.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, B=0, gray_out=0, valid=0, tc=0 and busy=0, independent of clk.
REQ-030 Reset asserted mid-RUN SHALL discard any pending step; after release the block SHALL wait in IDLE for start.

Configuration
REQ-031 Macro GRAY_CNT_DOWN_EN defined: port dn exists and down-counting per REQ-020 to REQ-025 is supported.
REQ-032 Macro GRAY_CNT_DOWN_EN undefined: port dn is absent, counting is up-only, and the terminal count is always all-ones.

Verification
REQ-033 Reset, start=1, ready=1 for 5 cycles -> gray_out 0x00, 0x01, 0x03, 0x02, 0x06 on successive cycles; valid=1 throughout.
REQ-034 ld_gray=0xE6 with ld=1, then one step up -> B=0xBB after load and gray_out=0xE2 after the step.
REQ-035 WRAP=1, ld_gray=0x80 (B=0xFF), step -> tc=1 before the step, then gray_out=0x00, tc=0, still RUN.
REQ-036 WRAP=0, ld_gray=0x80 in RUN, step -> DONE, valid=0, tc=1, busy=1, gray_out=0x80; start -> RUN with gray_out=0x00.
REQ-037 GRAY_CNT_DOWN_EN defined, dn=1, from reset, start, step -> gray_out=0x80 (B=0xFF); ready=0 for 3 cycles -> gray_out held at 0x80.
REQ-038 rst pulsed between edges mid-RUN at gray_out=0x06 -> outputs 0 immediately, valid=0, FSM in IDLE.
